tx_framer: RTL and testbench



---
 rtl/tx_pkg.sv | 20 ++
 rtl/tx_framer.sv | 136 +++++++++++++
 tb/tb_tx_framer.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_pkg.sv
// Shared symbol codes and framer states for the 8b/10b transmit/receive path.
package tx_pkg;

   // Control characters, named after their 8b/10b K-code.
   localparam logic [7:0] K28_5 = 8'hBC;  // idle comma
   localparam logic [7:0] K27_7 = 8'hFB;  // start of frame
   localparam logic [7:0] K29_7 = 8'hFD;  // end of frame
   localparam logic [7:0] K23_7 = 8'hF7;  // in-frame fill on source underrun
   localparam logic [7:0] K30_7 = 8'hFE;  // frame abort

   // SOF has no state of its own: it is emitted on the IDLE->DATA transition.
   typedef enum logic [2:0] {
      IDLE,
      DATA,
      EOF,
      ABORT,
      DRAIN
   } framer_state_t;

endpackage

// File: rtl/tx_framer.sv
// Transmit framer: turns a valid/ready/last byte stream into one {eb, k} symbol
// per clock for an encoder that never stalls, with commas, fill and aborts.
module tx_framer
   import tx_pkg::*;
#(
   parameter int IDLE_MIN  = 2,
   parameter int MAX_STALL = 4,
   parameter int MAX_LEN   = 256
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic [7:0] eb,
   output logic       k,
   output logic       frame_done,
   output logic       frame_abort,
   output logic       busy
);

   localparam int GW = $clog2(IDLE_MIN + 1);
   localparam int SW = $clog2(MAX_STALL + 1);
   localparam int LW = $clog2(MAX_LEN + 1);

   localparam logic [GW-1:0] GAP_MIN   = GW'(IDLE_MIN);
   localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);
   localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);

   framer_state_t state, state_n;
   logic [GW-1:0] gap_cnt, gap_n;
   logic [SW-1:0] stall_cnt, stall_n, stall_inc;
   logic [LW-1:0] len_cnt, len_n, len_inc;
   logic [7:0]    eb_n;
   logic          k_n, done_n, abort_n;
   logic          accept;

   // Handshake: a byte transfers on any edge where in_valid && in_ready; the
   // source holds in_data/in_last stable until then, and in_ready depends only
   // on state so it never combinationally follows in_valid.
   assign in_ready  = (state == DATA) || (state == DRAIN);
   assign busy      = (state == DATA) || (state == EOF) || (state == DRAIN);
   assign accept    = in_valid && in_ready;
   assign stall_inc = stall_cnt + 1'b1;
   assign len_inc   = len_cnt + 1'b1;

   always_comb begin
      state_n = state;
      gap_n   = gap_cnt;
      stall_n = stall_cnt;
      len_n   = len_cnt;
      eb_n    = K28_5;
      k_n     = 1'b1;
      done_n  = 1'b0;
      abort_n = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid && (gap_cnt >= GAP_MIN)) begin
               eb_n    = K27_7;
               state_n = DATA;
            end else if (gap_cnt < GAP_MIN) begin
               gap_n = gap_cnt + 1'b1;
            end
         end
         DATA: begin
            if (accept) begin
               eb_n    = in_data;
               k_n     = 1'b0;
               len_n   = len_inc;
               stall_n = '0;
               // A last byte landing exactly on the length limit still closes cleanly.
               if (in_last) begin
                  state_n = EOF;
               end else if (len_inc == LEN_MAX) begin
                  state_n = ABORT;
               end
            end else begin
               stall_n = stall_inc;
               if (stall_inc == STALL_MAX) begin
                  eb_n    = K30_7;
                  abort_n = 1'b1;
                  state_n = DRAIN;
               end else begin
                  eb_n = K23_7;
               end
            end
         end
         EOF: begin
            eb_n    = K29_7;
            done_n  = 1'b1;
            gap_n   = '0;
            len_n   = '0;
            state_n = IDLE;
         end
         ABORT: begin
            eb_n    = K30_7;
            abort_n = 1'b1;
            state_n = DRAIN;
         end
         DRAIN: begin
            // Swallow the rest of the aborted frame; commas here do not count as gap.
            if (accept && in_last) begin
               gap_n   = '0;
               stall_n = '0;
               len_n   = '0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         gap_cnt     <= '0;
         stall_cnt   <= '0;
         len_cnt     <= '0;
         eb          <= K28_5;
         k           <= 1'b1;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         state       <= state_n;
         gap_cnt     <= gap_n;
         stall_cnt   <= stall_n;
         len_cnt     <= len_n;
         eb          <= eb_n;
         k           <= k_n;
         frame_done  <= done_n;
         frame_abort <= abort_n;
      end
   end

endmodule

// File: tb/tb_tx_framer.sv
// Self-checking bench for tx_framer: scripted byte source plus an expected-symbol queue.
module tb_tx_framer;

   localparam int IDLE_MIN  = 2;
   localparam int MAX_STALL = 4;
   localparam int MAX_LEN   = 16;

   // Expected word layout: {frame_done, frame_abort, k, eb}.
   localparam logic [10:0] W_BC = {1'b0, 1'b0, 1'b1, 8'hBC};
   localparam logic [10:0] W_FB = {1'b0, 1'b0, 1'b1, 8'hFB};
   localparam logic [10:0] W_F7 = {1'b0, 1'b0, 1'b1, 8'hF7};
   localparam logic [10:0] W_FD = {1'b1, 1'b0, 1'b1, 8'hFD};
   localparam logic [10:0] W_FE = {1'b0, 1'b1, 1'b1, 8'hFE};
   localparam logic [9:0]  BUBBLE = 10'h000;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       in_ready;
   logic [7:0] eb;
   logic       k;
   logic       frame_done;
   logic       frame_abort;
   logic       busy;

   logic [9:0]  src_q[$];   // {valid, last, data}; valid entries wait for acceptance
   logic [10:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   tx_framer #(
      .IDLE_MIN (IDLE_MIN),
      .MAX_STALL(MAX_STALL),
      .MAX_LEN  (MAX_LEN)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .eb         (eb),
      .k          (k),
      .frame_done (frame_done),
      .frame_abort(frame_abort),
      .busy       (busy)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (time %0t, limit 100000)", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   function automatic logic [9:0] byt(input logic [7:0] d, input logic last);
      return {1'b1, last, d};
   endfunction

   function automatic logic [10:0] dat(input logic [7:0] d);
      return {3'b000, d};
   endfunction

   // One clock: present the source head, note whether it transfers, then
   // sample just after the edge so the caller sees this cycle's symbol.
   task automatic step();
      logic take;
      @(negedge clk);
      if (src_q.size() > 0) {in_valid, in_last, in_data} = src_q[0];
      else begin
         in_valid = 1'b0;
         in_last  = 1'b0;
         in_data  = 8'h00;
      end
      #1;
      take = in_valid && in_ready && !reset;
      @(posedge clk);
      #1;
      if (src_q.size() > 0 && !reset && (take || !src_q[0][9])) void'(src_q.pop_front());
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic push_gap_sof();
      exp_q.push_back(W_BC);
      exp_q.push_back(W_BC);
      exp_q.push_back(W_FB);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      src_q.delete();
      reset = 1'b1;
      step();
      step();
      n_tests++; if (eb !== 8'hBC) begin n_fail++; $display("FAIL reset_eb: got %h expected bc", eb); end
      n_tests++; if (k !== 1'b1) begin n_fail++; $display("FAIL reset_k: got %b expected 1", k); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      n_tests++; if (frame_done !== 1'b0 || frame_abort !== 1'b0) begin
         n_fail++; $display("FAIL reset_pulses: got done=%b abort=%b expected 0/0", frame_done, frame_abort);
      end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
   endtask

   task automatic test_basic_frame();
      logic [10:0] exp;
      int cyc = 0;
      src_q.delete(); exp_q.delete();
      src_q.push_back(byt(8'h11, 1'b0));
      src_q.push_back(byt(8'h22, 1'b0));
      src_q.push_back(byt(8'h33, 1'b1));
      pulse_reset();
      push_gap_sof();
      exp_q.push_back(dat(8'h11));
      exp_q.push_back(dat(8'h22));
      exp_q.push_back(dat(8'h33));
      exp_q.push_back(W_FD);
      exp_q.push_back(W_BC);
      exp_q.push_back(W_BC);
      while (exp_q.size() > 0) begin
         step();
         exp = exp_q.pop_front();
         n_tests++;
         if ({frame_done, frame_abort, k, eb} !== exp) begin
            n_fail++;
            $display("FAIL basic_frame cycle %0d: got %h expected %h", cyc, {frame_done, frame_abort, k, eb}, exp);
         end
         if (cyc == 3) begin
            n_tests++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
         end
         cyc++;
      end
   endtask

   task automatic test_underrun_fill();
      logic [10:0] exp;
      int cyc = 0;
      src_q.delete(); exp_q.delete();
      src_q.push_back(byt(8'hAA, 1'b0));
      src_q.push_back(BUBBLE);
      src_q.push_back(BUBBLE);
      src_q.push_back(byt(8'hBB, 1'b1));
      pulse_reset();
      push_gap_sof();
      exp_q.push_back(dat(8'hAA));
      exp_q.push_back(W_F7);
      exp_q.push_back(W_F7);
      exp_q.push_back(dat(8'hBB));
      exp_q.push_back(W_FD);
      exp_q.push_back(W_BC);
      while (exp_q.size() > 0) begin
         step();
         exp = exp_q.pop_front();
         n_tests++;
         if ({frame_done, frame_abort, k, eb} !== exp) begin
            n_fail++;
            $display("FAIL underrun_fill cycle %0d: got %h expected %h", cyc, {frame_done, frame_abort, k, eb}, exp);
         end
         cyc++;
      end
   endtask

   task automatic test_stall_abort();
      logic [10:0] exp;
      int cyc = 0;
      src_q.delete(); exp_q.delete();
      src_q.push_back(byt(8'h01, 1'b0));
      for (int i = 0; i < MAX_STALL; i++) src_q.push_back(BUBBLE);
      src_q.push_back(byt(8'h02, 1'b0));
      src_q.push_back(byt(8'h03, 1'b1));
      src_q.push_back(byt(8'h44, 1'b1));
      pulse_reset();
      push_gap_sof();
      exp_q.push_back(dat(8'h01));
      exp_q.push_back(W_F7);
      exp_q.push_back(W_F7);
      exp_q.push_back(W_F7);
      exp_q.push_back(W_FE);
      exp_q.push_back(W_BC);   // 02 drained
      exp_q.push_back(W_BC);   // 03 drained, back to idle
      push_gap_sof();
      exp_q.push_back(dat(8'h44));
      exp_q.push_back(W_FD);
      exp_q.push_back(W_BC);
      while (exp_q.size() > 0) begin
         step();
         exp = exp_q.pop_front();
         n_tests++;
         if ({frame_done, frame_abort, k, eb} !== exp) begin
            n_fail++;
            $display("FAIL stall_abort cycle %0d: got %h expected %h", cyc, {frame_done, frame_abort, k, eb}, exp);
         end
         if (exp == W_FE) begin
            n_tests++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_drain_ready: got %b expected 1", in_ready); end
         end
         cyc++;
      end
   endtask

   task automatic test_len_overrun();
      logic [10:0] exp;
      int cyc = 0;
      src_q.delete(); exp_q.delete();
      for (int i = 0; i <= MAX_LEN; i++) src_q.push_back(byt(8'(i), i == MAX_LEN));
      src_q.push_back(byt(8'h77, 1'b1));
      pulse_reset();
      push_gap_sof();
      for (int i = 0; i < MAX_LEN; i++) exp_q.push_back(dat(8'(i)));
      exp_q.push_back(W_FE);
      exp_q.push_back(W_BC);   // byte 10 dropped while draining
      push_gap_sof();
      exp_q.push_back(dat(8'h77));
      exp_q.push_back(W_FD);
      while (exp_q.size() > 0) begin
         step();
         exp = exp_q.pop_front();
         n_tests++;
         if ({frame_done, frame_abort, k, eb} !== exp) begin
            n_fail++;
            $display("FAIL len_overrun cycle %0d: got %h expected %h", cyc, {frame_done, frame_abort, k, eb}, exp);
         end
         cyc++;
      end
   endtask

   task automatic test_len_exact();
      logic [10:0] exp;
      int cyc = 0;
      src_q.delete(); exp_q.delete();
      for (int i = 0; i < MAX_LEN; i++) src_q.push_back(byt(8'(8'h80 + i), i == MAX_LEN - 1));
      pulse_reset();
      push_gap_sof();
      for (int i = 0; i < MAX_LEN; i++) exp_q.push_back(dat(8'(8'h80 + i)));
      exp_q.push_back(W_FD);
      exp_q.push_back(W_BC);
      while (exp_q.size() > 0) begin
         step();
         exp = exp_q.pop_front();
         n_tests++;
         if ({frame_done, frame_abort, k, eb} !== exp) begin
            n_fail++;
            $display("FAIL len_exact cycle %0d: got %h expected %h", cyc, {frame_done, frame_abort, k, eb}, exp);
         end
         cyc++;
      end
   endtask

   task automatic test_back_to_back();
      logic [10:0] exp;
      int cyc = 0;
      src_q.delete(); exp_q.delete();
      src_q.push_back(byt(8'h5A, 1'b1));
      src_q.push_back(byt(8'hA5, 1'b1));
      pulse_reset();
      push_gap_sof();
      exp_q.push_back(dat(8'h5A));
      exp_q.push_back(W_FD);
      push_gap_sof();
      exp_q.push_back(dat(8'hA5));
      exp_q.push_back(W_FD);
      exp_q.push_back(W_BC);
      while (exp_q.size() > 0) begin
         step();
         exp = exp_q.pop_front();
         n_tests++;
         if ({frame_done, frame_abort, k, eb} !== exp) begin
            n_fail++;
            $display("FAIL back_to_back cycle %0d: got %h expected %h", cyc, {frame_done, frame_abort, k, eb}, exp);
         end
         cyc++;
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [10:0] exp;
      int cyc = 0;
      src_q.delete(); exp_q.delete();
      src_q.push_back(byt(8'hC1, 1'b0));
      src_q.push_back(byt(8'hC2, 1'b0));
      src_q.push_back(byt(8'hC3, 1'b1));
      pulse_reset();
      push_gap_sof();
      exp_q.push_back(dat(8'hC1));
      while (exp_q.size() > 0) begin
         step();
         exp = exp_q.pop_front();
         n_tests++;
         if ({frame_done, frame_abort, k, eb} !== exp) begin
            n_fail++;
            $display("FAIL mid_reset_pre cycle %0d: got %h expected %h", cyc, {frame_done, frame_abort, k, eb}, exp);
         end
         cyc++;
      end
      // C2 is on the bus with in_ready high when reset hits.
      reset = 1'b1;
      step();
      n_tests++;
      if ({frame_done, frame_abort, k, eb} !== W_BC) begin
         n_fail++; $display("FAIL mid_reset_sym: got %h expected %h", {frame_done, frame_abort, k, eb}, W_BC);
      end
      n_tests++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_flags: got ready=%b busy=%b expected 0/0", in_ready, busy);
      end
      reset = 1'b0;
      src_q.delete();
      src_q.push_back(byt(8'hD4, 1'b1));
      push_gap_sof();
      exp_q.push_back(dat(8'hD4));
      exp_q.push_back(W_FD);
      cyc = 0;
      while (exp_q.size() > 0) begin
         step();
         exp = exp_q.pop_front();
         n_tests++;
         if ({frame_done, frame_abort, k, eb} !== exp) begin
            n_fail++;
            $display("FAIL mid_reset_post cycle %0d: got %h expected %h", cyc, {frame_done, frame_abort, k, eb}, exp);
         end
         cyc++;
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic_frame();
      test_underrun_fill();
      test_stall_abort();
      test_len_overrun();
      test_len_exact();
      test_back_to_back();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
